// File: rtl/gpp_apb_arbiter_pkg.sv
// Shared types and constants for the General Peripheral Port APB arbiter
// and the round-robin picker reused by later GPP masters.
package gpp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } gpp_state_e;

  localparam int GPP_ADDR_W      = 12;
  localparam int GPP_DATA_W      = 32;
  localparam int GPP_TIMEOUT_DEF = 256;

endpackage

// File: rtl/gpp_apb_arbiter_if.sv
// Bundles the requester-side APB signals and the single GPP master port.
// "master" is the arbiter's view; "slave" is the environment's view.
interface gpp_apb_arbiter_if
  import gpp_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = GPP_ADDR_W,
  parameter int DATA_W  = GPP_DATA_W
);

  logic [NUM_REQ-1:0]        s_psel;
  logic [NUM_REQ-1:0]        s_penable;
  logic [NUM_REQ-1:0]        s_pwrite;
  logic [NUM_REQ*ADDR_W-1:0] s_paddr;
  logic [NUM_REQ*DATA_W-1:0] s_pwdata;
  logic [DATA_W-1:0]         s_prdata;
  logic [NUM_REQ-1:0]        s_pready;
  logic [NUM_REQ-1:0]        s_pslverr;

  logic [ADDR_W-1:0]         m_paddr;
  logic [DATA_W-1:0]         m_pwdata;
  logic                      m_pwrite;
  logic                      m_psel;
  logic                      m_penable;
  logic [DATA_W-1:0]         m_prdata;
  logic                      m_pready;
  logic                      m_pslverr;

  logic [NUM_REQ-1:0]        grant_o;
  logic                      timeout_o;

  modport master (
    input  s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    output s_prdata, s_pready, s_pslverr,
    output m_paddr, m_pwdata, m_pwrite, m_psel, m_penable,
    input  m_prdata, m_pready, m_pslverr,
    output grant_o, timeout_o
  );

  modport slave (
    output s_psel, s_penable, s_pwrite, s_paddr, s_pwdata,
    input  s_prdata, s_pready, s_pslverr,
    input  m_paddr, m_pwdata, m_pwrite, m_psel, m_penable,
    output m_prdata, m_pready, m_pslverr,
    input  grant_o, timeout_o
  );

endinterface

// File: rtl/gpp_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Outputs a one-hot grant and the winner index.
module gpp_rr_pick
  import gpp_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  int               cand_int;
  logic [PTR_W-1:0] cand;

  // Scan from the farthest candidate down so the one nearest ptr is the last writer.
  always_comb begin
    gnt      = '0;
    idx      = '0;
    cand_int = 0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_int = int'(ptr) + k;
      if (cand_int >= NUM_REQ) cand_int = cand_int - NUM_REQ;
      cand = PTR_W'(cand_int);
      if (req[cand]) begin
        gnt       = '0;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/gpp_apb_arbiter.sv
// Round-robin arbiter sharing the single GPP APB master between NUM_REQ
// requesters; one complete re-timed transfer per grant, with a pready watchdog.
module gpp_apb_arbiter
  import gpp_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = GPP_ADDR_W,
  parameter int DATA_W  = GPP_DATA_W,
  parameter int TIMEOUT = GPP_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  gpp_apb_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(NUM_REQ - 1);

  gpp_state_e         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   wdog;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_write;

  logic [ADDR_W-1:0]  m_paddr_q;
  logic [DATA_W-1:0]  m_pwdata_q;
  logic               m_pwrite_q;
  logic               m_psel_q;
  logic               m_penable_q;
  logic [DATA_W-1:0]  s_prdata_q;
  logic [NUM_REQ-1:0] s_pready_q;
  logic [NUM_REQ-1:0] s_pslverr_q;
  logic [NUM_REQ-1:0] grant_q;
  logic               timeout_q;

  // Sequencing is driven by psel alone; penable is carried for protocol completeness.
  logic unused_penable;
  assign unused_penable = ^bus.s_penable;

  gpp_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req (bus.s_psel),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_addr  = bus.s_paddr[i*ADDR_W +: ADDR_W];
        sel_wdata = bus.s_pwdata[i*DATA_W +: DATA_W];
        sel_write = bus.s_pwrite[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wdog        <= '0;
      m_paddr_q   <= '0;
      m_pwdata_q  <= '0;
      m_pwrite_q  <= 1'b0;
      m_psel_q    <= 1'b0;
      m_penable_q <= 1'b0;
      s_prdata_q  <= '0;
      s_pready_q  <= '0;
      s_pslverr_q <= '0;
      grant_q     <= '0;
      timeout_q   <= 1'b0;
    end else begin
      s_prdata_q  <= '0;
      s_pready_q  <= '0;
      s_pslverr_q <= '0;
      timeout_q   <= 1'b0;
      case (state)
        // IDLE -> SETUP: latch the winner's transfer so later input changes cannot leak in
        IDLE: begin
          if (|bus.s_psel) begin
            state       <= SETUP;
            grant_q     <= pick_gnt;
            rr_ptr      <= (pick_idx == PTR_MAX) ? '0 : pick_idx + 1'b1;
            m_paddr_q   <= sel_addr;
            m_pwdata_q  <= sel_wdata;
            m_pwrite_q  <= sel_write;
            m_psel_q    <= 1'b1;
            m_penable_q <= 1'b0;
          end
        end
        // SETUP -> ACCESS
        SETUP: begin
          state       <= ACCESS;
          m_penable_q <= 1'b1;
        end
        // ACCESS -> RESP on pready (which beats a coincident timeout) or watchdog expiry
        ACCESS: begin
          if (bus.m_pready) begin
            state       <= RESP;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            s_pready_q  <= grant_q;
            s_prdata_q  <= bus.m_prdata;
            s_pslverr_q <= grant_q & {NUM_REQ{bus.m_pslverr}};
          end else if ((TIMEOUT != 0) && (wdog == WD_LAST)) begin
            state       <= RESP;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            s_pready_q  <= grant_q;
            s_pslverr_q <= grant_q;
            timeout_q   <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        // RESP -> IDLE: response pulse is visible this cycle
        RESP: begin
          state   <= IDLE;
          grant_q <= '0;
          wdog    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_paddr   = m_paddr_q;
  assign bus.m_pwdata  = m_pwdata_q;
  assign bus.m_pwrite  = m_pwrite_q;
  assign bus.m_psel    = m_psel_q;
  assign bus.m_penable = m_penable_q;
  assign bus.s_prdata  = s_prdata_q;
  assign bus.s_pready  = s_pready_q;
  assign bus.s_pslverr = s_pslverr_q;
  assign bus.grant_o   = grant_q;
  assign bus.timeout_o = timeout_q;

endmodule

// File: tb/tb_gpp_apb_arbiter.sv
// Directed bench for gpp_apb_arbiter: a table of whole-transfer vectors plus
// hand-written sequences for exact latency and reset-in-ACCESS.
module tb_gpp_apb_arbiter;
  import gpp_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int TO   = 8;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  write;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    int          waits;
    logic        slverr;
    logic [31:0] rdata;
    logic [1:0]  exp_grant;
    logic [11:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_write;
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  gpp_apb_arbiter_if #(.NUM_REQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) bus ();

  gpp_apb_arbiter #(
    .NUM_REQ (NREQ),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_m_psel"},    32'(bus.m_psel),    32'h0);
    chk({nm, "_m_penable"}, 32'(bus.m_penable), 32'h0);
    chk({nm, "_m_paddr"},   32'(bus.m_paddr),   32'h0);
    chk({nm, "_m_pwdata"},  bus.m_pwdata,       32'h0);
    chk({nm, "_m_pwrite"},  32'(bus.m_pwrite),  32'h0);
    chk({nm, "_s_pready"},  32'(bus.s_pready),  32'h0);
    chk({nm, "_s_pslverr"}, 32'(bus.s_pslverr), 32'h0);
    chk({nm, "_s_prdata"},  bus.s_prdata,       32'h0);
    chk({nm, "_grant"},     32'(bus.grant_o),   32'h0);
    chk({nm, "_timeout"},   32'(bus.timeout_o), 32'h0);
  endtask

  function automatic vec_t mkv(
    input logic [1:0] req, input logic [1:0] write,
    input logic [11:0] a0, input logic [11:0] a1,
    input logic [31:0] w0, input logic [31:0] w1,
    input int waits, input logic slverr, input logic [31:0] rdata,
    input logic [1:0] eg, input logic [11:0] ea, input logic [31:0] ew,
    input logic ewr, input int eacc, input logic eerr,
    input logic [31:0] erd, input logic eto);
    vec_t v;
    v.req = req; v.write = write; v.addr0 = a0; v.addr1 = a1;
    v.wdata0 = w0; v.wdata1 = w1; v.waits = waits; v.slverr = slverr;
    v.rdata = rdata; v.exp_grant = eg; v.exp_addr = ea; v.exp_wdata = ew;
    v.exp_write = ewr; v.exp_acc = eacc; v.exp_err = eerr;
    v.exp_rdata = erd; v.exp_to = eto;
    return v;
  endfunction

  // One full transfer; entered and left on the negedge of an IDLE cycle.
  task automatic run_vec(input int id, input vec_t v);
    int    n;
    int    k;
    string p;
    p = $sformatf("v%0d", id);
    bus.s_psel    = v.req;
    bus.s_penable = v.req;
    bus.s_pwrite  = v.write;
    bus.s_paddr   = {v.addr1, v.addr0};
    bus.s_pwdata  = {v.wdata1, v.wdata0};
    bus.m_pready  = 1'b0;
    bus.m_pslverr = v.slverr;
    bus.m_prdata  = v.rdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_psel && n < 10);
    chk({p, "_setup_seen"}, 32'(bus.m_psel),    32'h1);
    chk({p, "_setup_pen"},  32'(bus.m_penable), 32'h0);
    chk({p, "_grant"},      32'(bus.grant_o),   32'(v.exp_grant));
    chk({p, "_paddr"},      32'(bus.m_paddr),   32'(v.exp_addr));
    chk({p, "_pwdata"},     bus.m_pwdata,       v.exp_wdata);
    chk({p, "_pwrite"},     32'(bus.m_pwrite),  32'(v.exp_write));
    // Scramble requester inputs: the latched transfer must not follow them.
    bus.s_paddr  = ~{v.addr1, v.addr0};
    bus.s_pwdata = ~{v.wdata1, v.wdata0};
    bus.s_pwrite = ~v.write;
    @(negedge clk);
    k = 0;
    while (bus.m_penable && k < 40) begin
      k++;
      bus.m_pready = (k == v.waits + 1);
      @(negedge clk);
    end
    bus.m_pready = 1'b0;
    chk({p, "_acc_cycles"}, 32'(k),              32'(v.exp_acc));
    chk({p, "_resp_psel"},  32'(bus.m_psel),     32'h0);
    chk({p, "_resp_addr"},  32'(bus.m_paddr),    32'(v.exp_addr));
    chk({p, "_s_pready"},   32'(bus.s_pready),   32'(v.exp_grant));
    chk({p, "_s_pslverr"},  32'(bus.s_pslverr),  v.exp_err ? 32'(v.exp_grant) : 32'h0);
    chk({p, "_s_prdata"},   bus.s_prdata,        v.exp_rdata);
    chk({p, "_timeout"},    32'(bus.timeout_o),  32'(v.exp_to));
    bus.s_psel    = bus.s_psel & ~v.exp_grant;
    bus.s_penable = bus.s_psel;
    @(negedge clk);
    chk({p, "_idle_pready"},  32'(bus.s_pready),  32'h0);
    chk({p, "_idle_timeout"}, 32'(bus.timeout_o), 32'h0);
    chk({p, "_idle_prdata"},  bus.s_prdata,       32'h0);
    chk({p, "_idle_grant"},   32'(bus.grant_o),   32'h0);
    chk({p, "_idle_psel"},    32'(bus.m_psel),    32'h0);
  endtask

  vec_t vecs[12];

  initial begin
    int n;
    //            req    wr     a0      a1      w0            w1            wt  se    rdata         grant  addr    wdata         wr  acc err  rdata         to
    vecs[0]  = mkv(2'b10, 2'b00, 12'h000, 12'h020, 32'h0,        32'h0,        3,  1'b0, 32'h12345678, 2'b10, 12'h020, 32'h0,        0,  4, 1'b0, 32'h12345678, 1'b0);
    vecs[1]  = mkv(2'b11, 2'b01, 12'h100, 12'h200, 32'h11110000, 32'h5555AAAA, 0,  1'b0, 32'h0,        2'b01, 12'h100, 32'h11110000, 1,  1, 1'b0, 32'h0,        1'b0);
    vecs[2]  = mkv(2'b11, 2'b01, 12'h104, 12'h204, 32'h22220000, 32'h5555AAA1, 1,  1'b0, 32'hA0000001, 2'b10, 12'h204, 32'h5555AAA1, 0,  2, 1'b0, 32'hA0000001, 1'b0);
    vecs[3]  = mkv(2'b11, 2'b01, 12'h108, 12'h208, 32'h33330000, 32'h5555AAA2, 2,  1'b0, 32'h0,        2'b01, 12'h108, 32'h33330000, 1,  3, 1'b0, 32'h0,        1'b0);
    vecs[4]  = mkv(2'b11, 2'b01, 12'h10C, 12'h208, 32'h44440000, 32'h5555AAA3, 0,  1'b0, 32'hA0000002, 2'b10, 12'h208, 32'h5555AAA3, 0,  1, 1'b0, 32'hA0000002, 1'b0);
    vecs[5]  = mkv(2'b11, 2'b01, 12'h10C, 12'h20C, 32'h44440000, 32'h5555AAA4, 0,  1'b0, 32'h0,        2'b01, 12'h10C, 32'h44440000, 1,  1, 1'b0, 32'h0,        1'b0);
    vecs[6]  = mkv(2'b11, 2'b01, 12'h110, 12'h20C, 32'h55550000, 32'h5555AAA5, 2,  1'b0, 32'hA0000003, 2'b10, 12'h20C, 32'h5555AAA5, 0,  3, 1'b0, 32'hA0000003, 1'b0);
    vecs[7]  = mkv(2'b11, 2'b01, 12'h110, 12'h210, 32'h55550000, 32'h5555AAA6, 1,  1'b0, 32'h0,        2'b01, 12'h110, 32'h55550000, 1,  2, 1'b0, 32'h0,        1'b0);
    vecs[8]  = mkv(2'b11, 2'b01, 12'h114, 12'h210, 32'h66660000, 32'h5555AAA7, 0,  1'b0, 32'hA0000004, 2'b10, 12'h210, 32'h5555AAA7, 0,  1, 1'b0, 32'hA0000004, 1'b0);
    vecs[9]  = mkv(2'b01, 2'b01, 12'hFFC, 12'h000, 32'h0BADF00D, 32'h0,        0,  1'b1, 32'h0,        2'b01, 12'hFFC, 32'h0BADF00D, 1,  1, 1'b1, 32'h0,        1'b0);
    vecs[10] = mkv(2'b01, 2'b00, 12'h030, 12'h000, 32'h0,        32'h0,        100,1'b0, 32'hBAD0BAD0, 2'b01, 12'h030, 32'h0,        0,  8, 1'b1, 32'h0,        1'b1);
    vecs[11] = mkv(2'b01, 2'b00, 12'h0AC, 12'h000, 32'h0,        32'h0,        0,  1'b0, 32'hCAFEF00D, 2'b01, 12'h0AC, 32'h0,        0,  1, 1'b0, 32'hCAFEF00D, 1'b0);

    bus.s_psel = '0; bus.s_penable = '0; bus.s_pwrite = '0;
    bus.s_paddr = '0; bus.s_pwdata = '0;
    bus.m_prdata = '0; bus.m_pready = 1'b0; bus.m_pslverr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single write, zero-wait slave: exact t+1/t+2/t+3 latency.
    bus.s_psel = 2'b01; bus.s_penable = 2'b01; bus.s_pwrite = 2'b01;
    bus.s_paddr = {12'h0, 12'h010}; bus.s_pwdata = {32'h0, 32'hDEADBEEF};
    bus.m_pready = 1'b1; bus.m_prdata = '0;
    @(negedge clk);
    chk("wr_t1_psel",    32'(bus.m_psel),    32'h1);
    chk("wr_t1_penable", 32'(bus.m_penable), 32'h0);
    chk("wr_t1_paddr",   32'(bus.m_paddr),   32'h010);
    chk("wr_t1_pwdata",  bus.m_pwdata,       32'hDEADBEEF);
    chk("wr_t1_grant",   32'(bus.grant_o),   32'h1);
    @(negedge clk);
    chk("wr_t2_psel",    32'(bus.m_psel),    32'h1);
    chk("wr_t2_penable", 32'(bus.m_penable), 32'h1);
    chk("wr_t2_pwrite",  32'(bus.m_pwrite),  32'h1);
    @(negedge clk);
    chk("wr_t3_s_pready",  32'(bus.s_pready),  32'h1);
    chk("wr_t3_s_pslverr", 32'(bus.s_pslverr), 32'h0);
    chk("wr_t3_psel",      32'(bus.m_psel),    32'h0);
    bus.s_psel = '0; bus.s_penable = '0; bus.m_pready = 1'b0;
    @(negedge clk);
    chk("wr_t4_s_pready", 32'(bus.s_pready), 32'h0);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset during ACCESS: pointer now favours requester 1, reset must restore requester 0.
    bus.s_psel = 2'b11; bus.s_penable = 2'b11; bus.s_pwrite = 2'b00;
    bus.s_paddr = {12'h321, 12'h123}; bus.s_pwdata = '0;
    bus.m_pready = 1'b0; bus.m_pslverr = 1'b0; bus.m_prdata = 32'h77777777;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.m_penable && n < 10);
    chk("rst_reached_access", 32'(bus.m_penable), 32'h1);
    chk("rst_pre_grant",      32'(bus.grant_o),   32'h2);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rst_access");
    rst = 1'b0;
    @(negedge clk);
    chk("rst_after_psel",  32'(bus.m_psel),  32'h1);
    chk("rst_after_grant", 32'(bus.grant_o), 32'h1);
    chk("rst_after_paddr", 32'(bus.m_paddr), 32'h123);
    bus.m_pready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.s_pready == '0 && n < 10);
    chk("rst_after_s_pready", 32'(bus.s_pready), 32'h1);
    chk("rst_after_s_prdata", bus.s_prdata,      32'h77777777);
    bus.m_pready = 1'b0; bus.s_psel = '0; bus.s_penable = '0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
